buffered_matrixn_window_generator: RTL and testbench
====================================================

Name: buffered_matrixn_window_generator

Overview:
Single-clock successor to the 3x3 grayscale matrix converter. Converts a streamed RGB pixel to grayscale and buffers N-1 grayscale lines in internal line buffers. Emits one NxN neighbourhood window per valid interior pixel, where N is odd and set by parameter. It feeds the Sobel and other kernel stages and replaces the fixed 3x3, dual-clock path with a valid-qualified, frame-start-synchronised stream.

Parameters:
P_FRAME_COLUMNS, 640, active columns per frame (>= P_MATRIX_SIZE)
P_FRAME_ROWS, 480, active rows per frame (>= P_MATRIX_SIZE)
P_PIXEL_DEPTH, 24, RGB depth, multiple of 3
P_MATRIX_SIZE, 3, window dimension N, odd, 3..7
P_FRAME_COLUMN_BITS, $clog2(P_FRAME_COLUMNS), derived
P_FRAME_ROW_BITS, $clog2(P_FRAME_ROWS), derived
P_SUBPIXEL_DEPTH, P_PIXEL_DEPTH/3, derived
P_PIXEL_MATRIX_BITS, P_SUBPIXEL_DEPTH*(N*N-1), derived; see Optional Feature

Ports:
I_CLK  in  1  clock, rising edge
I_RESET  in  1  asynchronous active-high reset
I_PIXEL_VALID  in  1  I_PIXEL valid this cycle
I_FRAME_START  in  1  marks the first pixel of a frame; sampled only with I_PIXEL_VALID
I_PIXEL  in  P_PIXEL_DEPTH  {R,G,B}, R in MSBs
O_PIXEL_COLUMN  out  P_FRAME_COLUMN_BITS  centre column of the window
O_PIXEL_ROW  out  P_FRAME_ROW_BITS  centre row of the window
O_PIXEL_MATRIX  out  P_PIXEL_MATRIX_BITS  grayscale window, row-major, top-left in MSBs, centre excluded
O_PIXEL_MATRIX_READY  out  1  one-cycle strobe: window outputs valid
O_FRAME_DONE  out  1  one-cycle strobe after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0. Line-buffer contents are don't-care but are gated by the counters.
- Grayscale: gray = (R + 2G + B) >> 2. Compute in P_SUBPIXEL_DEPTH+2 bits with no overflow, then keep the upper P_SUBPIXEL_DEPTH bits.
- FSM states:
  - IDLE -> ACTIVE on I_PIXEL_VALID & I_FRAME_START. That pixel is accepted as (row 0, col 0).
  - In IDLE, valid pixels without I_FRAME_START are dropped.
  - ACTIVE -> IDLE after accepting (P_FRAME_ROWS-1, P_FRAME_COLUMNS-1). O_FRAME_DONE pulses on the next cycle.
  - In ACTIVE, I_FRAME_START with valid restarts the frame: that pixel becomes (0,0), no O_FRAME_DONE, no window from stale lines.
- Counters advance only on accepted pixels. Column wraps from P_FRAME_COLUMNS-1 to 0 and increments the row.
- Line buffers: N-1 lines x P_FRAME_COLUMNS x P_SUBPIXEL_DEPTH. One read and one write per accepted pixel, same column index.
- Window register: N x N shift register. Shifts one column per accepted pixel; the new column is {N-1 line-buffer taps, current gray}.
- Window emission: pixel (r,c) is accepted with r >= N-1 and c >= N-1. Then O_PIXEL_MATRIX_READY asserts exactly 2 cycles later with centre (r-h, c-h), h = (N-1)/2.
  - Latency is fixed at 2 cycles regardless of valid gaps between pixels.
  - Windows never span a row wrap.
- Windows per frame: (P_FRAME_ROWS-N+1) * (P_FRAME_COLUMNS-N+1).
- When READY is low, O_PIXEL_MATRIX, O_PIXEL_COLUMN and O_PIXEL_ROW hold their last values.
- Gaps in I_PIXEL_VALID: the pipeline holds and no state changes. There is no backpressure; downstream must accept every strobe.
- Asynchronous reset mid-frame: all outputs 0 in the same cycle, no pending strobe survives, block returns to IDLE.

Optional Feature:
Macro BUFFERED_MATRIXN_CENTER_PIXEL_EN.
- Defined: P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH*N*N. The centre pixel is included at its row-major position.
- Undefined: the centre is excluded (default, Sobel-compatible format).
- Timing and all other behaviour are identical in both builds.

Test Plan:
1. Grayscale: N=3, COLUMNS=8, ROWS=6, constant R=0x10 G=0x20 B=0x30 -> every emitted window element = 0x20; 8 elements x 8 bits = 64-bit matrix.
2. First window: pixel value = row*8+col, fed continuously -> first READY 2 cycles after accepting (2,2). Centre (1,1), matrix = {0,1,2,8,10,16,17,18} in gray-equivalent values.
3. Count and done: full 8x6 frame, N=3 -> exactly 24 READY strobes, last centre (4,6). O_FRAME_DONE pulses once, 1 cycle after (5,7). With N=5 -> 8 strobes.
4. Valid gaps: random 0-3 idle cycles between pixels -> identical window sequence to scenario 2; each strobe exactly 2 cycles after its triggering pixel.
5. Restart: I_FRAME_START at (3,4) mid-frame -> no O_FRAME_DONE; no READY until new (2,2); then correct windows from new data only.
6. Reset: I_RESET asserted asynchronously mid-row 3 -> outputs 0 immediately. Valid pixels without I_FRAME_START after release are dropped with no READY.

Source files
------------

// File: rtl/buffered_matrixn_window_generator_if.sv
// Pixel-in / window-out bundle for buffered_matrixn_window_generator.
// BUFFERED_MATRIXN_CENTER_PIXEL_EN widens O_PIXEL_MATRIX to carry the centre pixel.
interface buffered_matrixn_window_generator_if #(
  parameter int unsigned P_FRAME_COLUMNS     = 640,
  parameter int unsigned P_FRAME_ROWS        = 480,
  parameter int unsigned P_PIXEL_DEPTH       = 24,
  parameter int unsigned P_MATRIX_SIZE       = 3,
  parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int unsigned P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3,
`ifdef BUFFERED_MATRIXN_CENTER_PIXEL_EN
  parameter int unsigned P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH * P_MATRIX_SIZE * P_MATRIX_SIZE
`else
  parameter int unsigned P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH * (P_MATRIX_SIZE * P_MATRIX_SIZE - 1)
`endif
);
  logic                           I_PIXEL_VALID;
  logic                           I_FRAME_START;
  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL;
  logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN;
  logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW;
  logic [P_PIXEL_MATRIX_BITS-1:0] O_PIXEL_MATRIX;
  logic                           O_PIXEL_MATRIX_READY;
  logic                           O_FRAME_DONE;

  // Pixel source side.
  modport master (
    output I_PIXEL_VALID, I_FRAME_START, I_PIXEL,
    input  O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX, O_PIXEL_MATRIX_READY, O_FRAME_DONE
  );

  // Window generator side.
  modport slave (
    input  I_PIXEL_VALID, I_FRAME_START, I_PIXEL,
    output O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX, O_PIXEL_MATRIX_READY, O_FRAME_DONE
  );
endinterface

// File: rtl/buffered_matrixn_window_generator.sv
// RGB -> grayscale, N-1 line buffers and an NxN sliding window emitted two cycles after its
// bottom-right pixel. Define BUFFERED_MATRIXN_CENTER_PIXEL_EN to include the centre pixel.
module buffered_matrixn_window_generator #(
  parameter int unsigned P_FRAME_COLUMNS     = 640,
  parameter int unsigned P_FRAME_ROWS        = 480,
  parameter int unsigned P_PIXEL_DEPTH       = 24,
  parameter int unsigned P_MATRIX_SIZE       = 3,
  parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int unsigned P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3,
`ifdef BUFFERED_MATRIXN_CENTER_PIXEL_EN
  parameter int unsigned P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH * P_MATRIX_SIZE * P_MATRIX_SIZE
`else
  parameter int unsigned P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH * (P_MATRIX_SIZE * P_MATRIX_SIZE - 1)
`endif
) (
  input logic I_CLK,
  input logic I_RESET,
  buffered_matrixn_window_generator_if.slave bus
);

  localparam int WinSize  = P_MATRIX_SIZE;
  localparam int HalfWin  = (WinSize - 1) / 2;
  localparam int SubDepth = P_SUBPIXEL_DEPTH;
  localparam int ColBits  = P_FRAME_COLUMN_BITS;
  localparam int RowBits  = P_FRAME_ROW_BITS;
  localparam int MatBits  = P_PIXEL_MATRIX_BITS;

  localparam logic [ColBits-1:0] LastCol  = ColBits'(P_FRAME_COLUMNS - 1);
  localparam logic [RowBits-1:0] LastRow  = RowBits'(P_FRAME_ROWS - 1);
  localparam logic [ColBits-1:0] EdgeCol  = ColBits'(WinSize - 1);
  localparam logic [RowBits-1:0] EdgeRow  = RowBits'(WinSize - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  typedef logic [WinSize-2:0][SubDepth-1:0] line_word_t;
  typedef logic [WinSize-1:0][WinSize-1:0][SubDepth-1:0] window_t;

  state_e             state_q, state_d;
  logic [ColBits-1:0] col_q, col_d, cur_col;
  logic [RowBits-1:0] row_q, row_d, cur_row;
  logic               restart, accept, last_pixel, win_hit;

  logic [SubDepth-1:0] red, green, blue, gray;
  logic [SubDepth+1:0] gray_sum;
  logic                unused_gray_lsb;

  // One word per column holds that column of all buffered lines; element 0 is the newest line.
  line_word_t line_q [P_FRAME_COLUMNS];
  line_word_t line_rd, line_wr;

  window_t            win_q, win_d;
  logic [MatBits-1:0] mat_d;

  logic               pend_q;
  logic [ColBits-1:0] pend_col_q;
  logic [RowBits-1:0] pend_row_q;
  logic               ready_q, done_q;
  logic [ColBits-1:0] out_col_q;
  logic [RowBits-1:0] out_row_q;
  logic [MatBits-1:0] out_mat_q;

  // Grayscale: (R + 2G + B) >> 2 with two guard bits so the sum cannot overflow.
  assign red             = bus.I_PIXEL[P_PIXEL_DEPTH-1 -: SubDepth];
  assign green           = bus.I_PIXEL[2*SubDepth-1 -: SubDepth];
  assign blue            = bus.I_PIXEL[SubDepth-1:0];
  assign gray_sum        = {2'b00, red} + {1'b0, green, 1'b0} + {2'b00, blue};
  assign gray            = gray_sum[SubDepth+1:2];
  assign unused_gray_lsb = ^gray_sum[1:0];

  // Frame-start with valid always lands at (0,0), in either state.
  assign restart    = bus.I_PIXEL_VALID && bus.I_FRAME_START;
  assign cur_col    = restart ? '0 : col_q;
  assign cur_row    = restart ? '0 : row_q;
  assign last_pixel = (cur_col == LastCol) && (cur_row == LastRow);
  assign win_hit    = accept && (cur_row >= EdgeRow) && (cur_col >= EdgeCol);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = 1'b0;
    case (state_q)
      StIdle:   accept = restart;
      StActive: accept = bus.I_PIXEL_VALID;
      default:  accept = 1'b0;
    endcase
    if (accept) begin
      if (last_pixel) begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = StActive;
        if (cur_col == LastCol) begin
          col_d = '0;
          row_d = cur_row + RowBits'(1);
        end else begin
          col_d = cur_col + ColBits'(1);
          row_d = cur_row;
        end
      end
    end
  end

  assign line_rd = line_q[cur_col];
  assign line_wr = {line_rd[WinSize-3:0], gray};

  // Shift the window left one column; the new right column is {line taps, current gray}.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < WinSize; i++) begin
        for (int j = 0; j < WinSize - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      win_d[WinSize-1][WinSize-1] = gray;
      for (int k = 0; k < WinSize - 1; k++) begin
        win_d[WinSize-2-k][WinSize-1] = line_rd[k];
      end
    end
  end

  // Row-major flatten, top-left in the MSBs.
  always_comb begin
    int  pos;
    logic keep;
    mat_d = '0;
    pos   = 0;
    keep  = 1'b0;
    for (int i = 0; i < WinSize; i++) begin
      for (int j = 0; j < WinSize; j++) begin
`ifdef BUFFERED_MATRIXN_CENTER_PIXEL_EN
        keep = 1'b1;
`else
        keep = !((i == HalfWin) && (j == HalfWin));
`endif
        if (keep) begin
          mat_d[MatBits-1-pos*SubDepth -: SubDepth] = win_q[i][j];
          pos = pos + 1;
        end
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    win_q <= win_d;
    if (accept) begin
      line_q[cur_col] <= line_wr;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      pend_q     <= 1'b0;
      pend_col_q <= '0;
      pend_row_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      out_mat_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pend_q  <= win_hit;
      if (win_hit) begin
        pend_col_q <= cur_col - ColBits'(HalfWin);
        pend_row_q <= cur_row - RowBits'(HalfWin);
      end
      // Second stage runs every cycle so latency stays fixed across valid gaps.
      ready_q <= pend_q;
      done_q  <= accept && last_pixel;
      if (pend_q) begin
        out_col_q <= pend_col_q;
        out_row_q <= pend_row_q;
        out_mat_q <= mat_d;
      end
    end
  end

  assign bus.O_PIXEL_COLUMN       = out_col_q;
  assign bus.O_PIXEL_ROW          = out_row_q;
  assign bus.O_PIXEL_MATRIX       = out_mat_q;
  assign bus.O_PIXEL_MATRIX_READY = ready_q;
  assign bus.O_FRAME_DONE         = done_q;

endmodule

// File: tb/tb_buffered_matrixn_window_generator.sv
// Drives an 8x6 frame stream into N=3 and N=5 instances and checks every cycle against an
// image-based reference model of the expected windows, strobes and frame-done pulses.
module tb_buffered_matrixn_window_generator;
  localparam int Cols = 8;
  localparam int Rows = 6;
`ifdef BUFFERED_MATRIXN_CENTER_PIXEL_EN
  localparam bit CenterEn = 1'b1;
`else
  localparam bit CenterEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, fs;
  logic [23:0] pix;

  always #5 clk = ~clk;

  buffered_matrixn_window_generator_if #(
    .P_FRAME_COLUMNS(Cols), .P_FRAME_ROWS(Rows), .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3)
  ) bus3 ();
  buffered_matrixn_window_generator_if #(
    .P_FRAME_COLUMNS(Cols), .P_FRAME_ROWS(Rows), .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5)
  ) bus5 ();

  assign bus3.I_PIXEL_VALID = valid;
  assign bus3.I_FRAME_START = fs;
  assign bus3.I_PIXEL       = pix;
  assign bus5.I_PIXEL_VALID = valid;
  assign bus5.I_FRAME_START = fs;
  assign bus5.I_PIXEL       = pix;

  buffered_matrixn_window_generator #(
    .P_FRAME_COLUMNS(Cols), .P_FRAME_ROWS(Rows), .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3)
  ) u_dut3 (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus3)
  );

  buffered_matrixn_window_generator #(
    .P_FRAME_COLUMNS(Cols), .P_FRAME_ROWS(Rows), .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5)
  ) u_dut5 (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus5)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            dut;
    int            col;
    int            row;
    logic [255:0]  mat;
  } ev_t;

  ev_t          evq[$];
  int           cyc = 0;
  int           img [Rows][Cols];
  bit           m_active = 1'b0;
  int           m_r = 0;
  int           m_c = 0;
  int           done_due = -1;
  int           exp_col [2];
  int           exp_row [2];
  logic [255:0] exp_mat [2];
  int           rdy_cnt [2];
  int           done_cnt = 0;
  int           first_col, first_row;
  logic [255:0] first_mat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] build_win(input int n, input int r, input int c);
    logic [255:0] m;
    int h;
    m = '0;
    h = (n - 1) / 2;
    for (int i = r - n + 1; i <= r; i++) begin
      for (int j = c - n + 1; j <= c; j++) begin
        if (CenterEn || i != r - h || j != c - h) m = (m << 8) | 256'(img[i][j] & 255);
      end
    end
    return m;
  endfunction

  task automatic check_dut(input int d, input logic rdy, input int col, input int row,
                           input logic [255:0] mat);
    int idx;
    idx = -1;
    foreach (evq[i]) begin
      if (idx < 0 && evq[i].dut == d && evq[i].due == cyc) idx = i;
    end
    if (idx >= 0) begin
      exp_col[d] = evq[idx].col;
      exp_row[d] = evq[idx].row;
      exp_mat[d] = evq[idx].mat;
      evq.delete(idx);
    end
    chk(d == 0 ? "ready_n3" : "ready_n5", 256'(rdy), 256'(idx >= 0));
    chk(d == 0 ? "column_n3" : "column_n5", 256'(col), 256'(exp_col[d]));
    chk(d == 0 ? "row_n3" : "row_n5", 256'(row), 256'(exp_row[d]));
    chk(d == 0 ? "matrix_n3" : "matrix_n5", mat, exp_mat[d]);
    if (rdy === 1'b1) begin
      rdy_cnt[d]++;
      if (d == 0 && rdy_cnt[0] == 1) begin
        first_col = col;
        first_row = row;
        first_mat = mat;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      evq.delete();
      m_active = 1'b0;
      m_r      = 0;
      m_c      = 0;
      done_due = -1;
      for (int d = 0; d < 2; d++) begin
        exp_col[d] = 0;
        exp_row[d] = 0;
        exp_mat[d] = '0;
      end
    end
    check_dut(0, bus3.O_PIXEL_MATRIX_READY, int'(bus3.O_PIXEL_COLUMN), int'(bus3.O_PIXEL_ROW),
              256'(bus3.O_PIXEL_MATRIX));
    check_dut(1, bus5.O_PIXEL_MATRIX_READY, int'(bus5.O_PIXEL_COLUMN), int'(bus5.O_PIXEL_ROW),
              256'(bus5.O_PIXEL_MATRIX));
    chk("frame_done_n3", 256'(bus3.O_FRAME_DONE), 256'(cyc == done_due));
    chk("frame_done_n5", 256'(bus5.O_FRAME_DONE), 256'(cyc == done_due));
    if (bus3.O_FRAME_DONE === 1'b1) done_cnt++;
    // Inputs visible now are sampled at the coming rising edge.
    if (!rst && valid) begin
      bit acc;
      acc = 1'b0;
      if (fs) begin
        m_active = 1'b1;
        m_r = 0;
        m_c = 0;
        acc = 1'b1;
      end else if (m_active) begin
        acc = 1'b1;
      end
      if (acc) begin
        img[m_r][m_c] = (int'(pix[23:16]) + 2 * int'(pix[15:8]) + int'(pix[7:0])) / 4;
        for (int d = 0; d < 2; d++) begin
          int  n;
          ev_t e;
          n = (d == 0) ? 3 : 5;
          if (m_r >= n - 1 && m_c >= n - 1) begin
            e.due = cyc + 2;
            e.dut = d;
            e.col = m_c - (n - 1) / 2;
            e.row = m_r - (n - 1) / 2;
            e.mat = build_win(n, m_r, m_c);
            evq.push_back(e);
          end
        end
        if (m_r == Rows - 1 && m_c == Cols - 1) begin
          done_due = cyc + 1;
          m_active = 1'b0;
        end else if (m_c == Cols - 1) begin
          m_c = 0;
          m_r++;
        end else begin
          m_c++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit f, input logic [23:0] p);
    valid = 1'b1;
    fs    = f;
    pix   = p;
    @(posedge clk);
    #1;
    valid = 1'b0;
    fs    = 1'b0;
  endtask

  // kind 0: constant colour, 1: ramp row*8+col, 2: random. Stops before (stop_r, stop_c).
  task automatic send_frame(input int kind, input int gap_max, input int stop_r, input int stop_c);
    logic [7:0]  v;
    logic [23:0] p;
    for (int r = 0; r < Rows; r++) begin
      for (int c = 0; c < Cols; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gap_max > 0) idle($urandom_range(gap_max, 0));
        v = 8'(r * Cols + c);
        case (kind)
          0:       p = 24'h102030;
          1:       p = {v, v, v};
          default: p = 24'($urandom);
        endcase
        send(r == 0 && c == 0, p);
      end
    end
  endtask

  task automatic clear_counts();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    done_cnt   = 0;
  endtask

  task automatic check_counts(input string tag, input int n3, input int n5, input int dn);
    chk({tag, "_strobes_n3"}, 256'(rdy_cnt[0]), 256'(n3));
    chk({tag, "_strobes_n5"}, 256'(rdy_cnt[1]), 256'(n5));
    chk({tag, "_frame_done"}, 256'(done_cnt), 256'(dn));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready3"}, 256'(bus3.O_PIXEL_MATRIX_READY), '0);
    chk({tag, "_done3"}, 256'(bus3.O_FRAME_DONE), '0);
    chk({tag, "_col3"}, 256'(bus3.O_PIXEL_COLUMN), '0);
    chk({tag, "_row3"}, 256'(bus3.O_PIXEL_ROW), '0);
    chk({tag, "_mat3"}, 256'(bus3.O_PIXEL_MATRIX), '0);
    chk({tag, "_ready5"}, 256'(bus5.O_PIXEL_MATRIX_READY), '0);
    chk({tag, "_done5"}, 256'(bus5.O_FRAME_DONE), '0);
    chk({tag, "_mat5"}, 256'(bus5.O_PIXEL_MATRIX), '0);
  endtask

  initial begin
    logic [255:0] k3, k5, first_exp;
    k3 = CenterEn ? 256'({9{8'h20}}) : 256'({8{8'h20}});
    k5 = CenterEn ? 256'({25{8'h20}}) : 256'({24{8'h20}});
    first_exp = CenterEn ? 256'(72'h00_01_02_08_09_0A_10_11_12)
                         : 256'(64'h00_01_02_08_0A_10_11_12);
    rst   = 1'b1;
    valid = 1'b0;
    fs    = 1'b0;
    pix   = '0;
    idle(3);
    check_all_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // Constant colour: every element is gray 0x20.
    clear_counts();
    send_frame(0, 0, -1, -1);
    idle(4);
    check_counts("const", 24, 8, 1);
    chk("const_last_row3", 256'(bus3.O_PIXEL_ROW), 256'(4));
    chk("const_last_col3", 256'(bus3.O_PIXEL_COLUMN), 256'(6));
    chk("const_mat3", 256'(bus3.O_PIXEL_MATRIX), k3);
    chk("const_last_row5", 256'(bus5.O_PIXEL_ROW), 256'(3));
    chk("const_last_col5", 256'(bus5.O_PIXEL_COLUMN), 256'(5));
    chk("const_mat5", 256'(bus5.O_PIXEL_MATRIX), k5);

    // Ramp, continuous and then with random valid gaps.
    for (int g = 0; g <= 3; g += 3) begin
      clear_counts();
      send_frame(1, g, -1, -1);
      idle(4);
      check_counts(g == 0 ? "ramp" : "ramp_gaps", 24, 8, 1);
      chk("first_col", 256'(first_col), 256'(1));
      chk("first_row", 256'(first_row), 256'(1));
      chk("first_mat", first_mat, first_exp);
    end

    // Restart in place of (3,4): partial frame gives only its own legal windows, no done.
    clear_counts();
    send_frame(1, 0, 3, 4);
    send_frame(2, 1, -1, -1);
    idle(4);
    check_counts("restart", 32, 8, 1);

    // Asynchronous reset mid row 3, then headless pixels are dropped.
    clear_counts();
    send_frame(2, 0, 3, 5);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    idle(2);
    #1 rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 20; i++) send(1'b0, 24'($urandom));
    idle(4);
    check_counts("headless", 0, 0, 0);

    // Recovery with a random frame and gaps.
    clear_counts();
    send_frame(2, 2, -1, -1);
    idle(4);
    check_counts("recover", 24, 8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
